profile_snapshot_ci: RTL and testbench

PROFILE_SNAPSHOT_CI -- requirements
Module: profile_snapshot_ci

---
 rtl/profile_snapshot_ci.sv | 147 ++++++++++++++
 tb/tb_profile_snapshot_ci.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/profile_snapshot_ci.sv
// Custom instruction that snapshots four live profiling counters into a circular FIFO.
// Define PROFILE_AUTOSNAP_EN to compile in the periodic auto-snapshot timer (opcode 4).
module profile_snapshot_ci #(
  parameter logic [7:0] customId = 8'd9,
  parameter int         DEPTH    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [31:0] counter0,
  input  logic [31:0] counter1,
  input  logic [31:0] counter2,
  input  logic [31:0] counter3,
  output logic        done,
  output logic [31:0] result
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef PROFILE_AUTOSNAP_EN
  localparam int OPW = 16;
`else
  localparam int OPW = 3;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_op;
  logic [OPW-1:0] r_opnd;
  logic [31:0]    r_result;
  logic [127:0]   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_ovf, r_udf;

  logic           w_accept, w_exec, w_empty, w_clear;
  logic           w_ci_push, w_auto_push, w_push_req, w_push, w_pop, w_auto_active;
  logic [127:0]   w_head;
  logic [4:0]     w_count5;
  logic [31:0]    w_exec_result;
  logic           w_unused;

  assign w_unused = ^{valueA[31:3], valueB[31:OPW]};

  assign w_accept = start && (ciN == customId) && (r_state == S_IDLE);
  assign w_exec   = (r_state == S_EXEC);
  assign w_empty  = (r_count == '0);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_count5 = 5'(r_count);

`ifdef PROFILE_AUTOSNAP_EN
  logic [15:0] r_interval, r_timer;
  logic        w_timer_hit;

  assign w_timer_hit   = (r_interval != 16'd0) && (r_timer == r_interval - 16'd1);
  assign w_auto_push   = w_timer_hit;
  assign w_auto_active = (r_interval != 16'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_interval <= 16'd0;
      r_timer    <= 16'd0;
    end else if (w_exec && r_op == 3'd4) begin
      r_interval <= r_opnd[15:0];
      r_timer    <= 16'd0;
    end else if (w_timer_hit) begin
      r_timer <= 16'd0;
    end else if (r_interval != 16'd0) begin
      r_timer <= r_timer + 16'd1;
    end
  end
`else
  assign w_auto_push   = 1'b0;
  assign w_auto_active = 1'b0;
`endif

  // A CI snapshot and a timer tick in the same cycle merge into one push.
  assign w_ci_push  = w_exec && (r_op == 3'd0);
  assign w_push_req = w_ci_push || w_auto_push;
  assign w_pop      = w_exec && (r_op == 3'd1) && r_opnd[2] && !w_empty;
  assign w_push     = w_push_req && ((r_count != FULL) || w_pop);
  assign w_clear    = w_exec && (r_op == 3'd3);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_exec_result = 32'd0;
    case (r_op)
      3'd1:    if (!w_empty) w_exec_result = w_head[{r_opnd[1:0], 5'd0} +: 32];
      3'd2:    w_exec_result = {r_ovf, r_udf, w_auto_active, 24'd0, w_count5};
      default: w_exec_result = 32'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_ovf    <= 1'b0;
        r_udf    <= 1'b0;
      end else begin
        if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        if (w_push_req && !w_push) r_ovf <= 1'b1;
        if (w_exec && r_op == 3'd1 && w_empty) r_udf <= 1'b1;
      end
    end
  end

  // Datapath registers carry no reset; their contents are qualified by the FSM.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_op   <= valueA[2:0];
      r_opnd <= valueB[OPW-1:0];
    end
    if (w_exec) r_result <= w_exec_result;
    if (w_push && !w_clear) r_mem[r_wr_ptr] <= {counter3, counter2, counter1, counter0};
  end

  assign done   = (r_state == S_DONE) && !reset;
  assign result = done ? r_result : 32'd0;

endmodule

// File: tb/tb_profile_snapshot_ci.sv
// Scoreboard bench for profile_snapshot_ci: directed instructions push expected
// results and completion cycles; a negedge monitor pops them on every done pulse.
module tb_profile_snapshot_ci;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [7:0]  ciN;
  logic [31:0] valueA, valueB;
  logic [31:0] counter0, counter1, counter2, counter3;
  logic        done;
  logic [31:0] result;

  profile_snapshot_ci #(.customId(8'd9), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN),
    .valueA(valueA), .valueB(valueB),
    .counter0(counter0), .counter1(counter1), .counter2(counter2), .counter3(counter3),
    .done(done), .result(result)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge clock) begin
    if (done) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done at cycle %0d result %h, no instruction outstanding", cyc, result);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.res || cyc != mon_e.at) begin
          n_fail++;
          $display("FAIL ci_result: got %h at cycle %0d, expected %h at cycle %0d",
                   result, cyc, mon_e.res, mon_e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns three negedges later with the FSM back in IDLE.
  task automatic issue(input logic [2:0] op, input logic [31:0] b, input logic [31:0] exp);
    exp_t e;
    start  = 1'b1;
    ciN    = 8'd9;
    valueA = {29'd0, op};
    valueB = b;
    e.res  = exp;
    e.at   = cyc + 2;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic set_counters(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
    counter0 = a; counter1 = b; counter2 = c; counter3 = d;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;
    set_counters(32'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);

    issue(3'd2, 32'd0, 32'h0000_0000);

    set_counters(32'h11, 32'h22, 32'h33, 32'h44);
    issue(3'd0, 32'd0, 32'd0);
    issue(3'd1, 32'h5, 32'h22);
    issue(3'd2, 32'd0, 32'h0000_0000);

    issue(3'd0, 32'd0, 32'd0);
    issue(3'd1, 32'h3, 32'h44);
    issue(3'd1, 32'h0, 32'h11);
    issue(3'd2, 32'd0, 32'h0000_0001);
    issue(3'd1, 32'h6, 32'h33);
    issue(3'd2, 32'd0, 32'h0000_0000);

    for (int i = 0; i <= DEPTH; i++) begin
      set_counters(32'h100 + i, 32'h200 + i, 32'h300 + i, 32'h400 + i);
      issue(3'd0, 32'd0, 32'd0);
    end
    set_counters(32'hdead0000, 32'hdead0001, 32'hdead0002, 32'hdead0003);
    issue(3'd2, 32'd0, 32'h8000_0008);
    for (int i = 0; i < DEPTH; i++)
      issue(3'd1, 32'h4 | (i % 4), 32'h100 * ((i % 4) + 1) + i);
    issue(3'd2, 32'd0, 32'h8000_0000);

    issue(3'd3, 32'd0, 32'd0);
    issue(3'd2, 32'd0, 32'h0000_0000);
    issue(3'd1, 32'h4, 32'h0);
    issue(3'd2, 32'd0, 32'h4000_0000);
    issue(3'd3, 32'd0, 32'd0);
    issue(3'd2, 32'd0, 32'h0000_0000);

    issue(3'd5, 32'hffff_ffff, 32'd0);
    issue(3'd6, 32'h5, 32'd0);
    issue(3'd7, 32'h0, 32'd0);
`ifndef PROFILE_AUTOSNAP_EN
    issue(3'd4, 32'd10, 32'd0);
`endif
    issue(3'd2, 32'd0, 32'h0000_0000);

    // Foreign ciN must be ignored entirely.
    start = 1'b1; ciN = 8'd8; valueA = 32'd0; valueB = 32'd0;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    issue(3'd2, 32'd0, 32'h0000_0000);

    // Second start while in EXEC is dropped: one done, one entry.
    begin
      exp_t e;
      start = 1'b1; ciN = 8'd9; valueA = 32'd0; valueB = 32'd0;
      e.res = 32'd0; e.at = cyc + 2;
      sb.push_back(e);
      @(negedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
    end
    issue(3'd2, 32'd0, 32'h0000_0001);

    // Reset in EXEC aborts with no done pulse and clears the FIFO.
    start = 1'b1; ciN = 8'd9; valueA = 32'd0;
    @(negedge clock);
    start = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    issue(3'd2, 32'd0, 32'h0000_0000);

`ifdef PROFILE_AUTOSNAP_EN
    issue(3'd4, 32'd10, 32'd0);
    issue(3'd2, 32'd0, 32'h2000_0000);
    repeat (17) @(negedge clock);
    issue(3'd4, 32'd0, 32'd0);
    issue(3'd2, 32'd0, 32'h0000_0002);
    repeat (20) @(negedge clock);
    issue(3'd2, 32'd0, 32'h0000_0002);
    issue(3'd3, 32'd0, 32'd0);
`endif

    repeat (5) @(negedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_done: %0d instructions never completed, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
